seg7_reader: RTL and testbench
==============================

SEG7_READER -- requirements
Module: seg7_reader

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4: consecutive identical samples needed to accept a pattern (legal 2..15).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: output queue entries (power of two, 2..16).
REQ-003 SHALL have port clk  in  1  single clock; all state on its rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port segments  in  7  display bus; bit0=top(1), bit1=upper-right(2), bit2=lower-right(3), bit3=bottom(4), bit4=lower-left(5), bit5=upper-left(6), bit6=middle(7).
REQ-006 SHALL have port out_code  out  4  decoded glyph code at FIFO head.
REQ-007 SHALL have port out_valid  out  1  out_code valid.
REQ-008 SHALL have port out_ready  in  1  consumer accepts; transfer when out_valid&&out_ready at a clock edge.
REQ-009 SHALL have port overflow  out  1  sticky: a glyph was dropped because the FIFO was full.
REQ-010 SHALL have port msg_done  out  1  one-cycle pulse when the full message is recognised.
REQ-011 SHALL have port msg_index  out  4  count of message glyphs matched so far.

Function
REQ-012 SHALL decode patterns to glyph codes: 0111110=U(0), 1110111=A(1), 1111100=B(2), 0111001=C(3), 1000000=-(4), 1111001=E(5), 0111000=L(6), 0110001=T(7), 1010000=R(8), 0111111=O(9), 1010100=N(10), 0110000=I(11), 0000000=blank(12); any other pattern = unknown(15).
REQ-013 SHALL register segments each cycle and count consecutive equal samples; a change restarts the count at 1; the count saturates.
REQ-014 SHALL accept a pattern at the edge where its count reaches STABLE_CYCLES, only if it differs from the last accepted pattern; each hold is accepted at most once.
REQ-015 SHALL drop a pattern held for fewer than STABLE_CYCLES samples (glitch filter).
REQ-016 SHALL record an accepted blank as the last accepted pattern but never write it to the FIFO, so a glyph can repeat when separated by blank.
REQ-017 SHALL push every accepted non-blank glyph, including unknown(15), into the FIFO; out_valid rises the cycle after acceptance.
REQ-018 SHALL drop the glyph and set overflow when the FIFO is full and no pop occurs that cycle; push with simultaneous pop on a full FIFO succeeds.
REQ-019 SHALL hold out_code stable while out_valid=1 and out_ready=0.
REQ-020 SHALL track the message U A B C - E L E C T R O N I C A: on each pushed glyph equal to the expected glyph, increment msg_index; on a mismatch, set msg_index to 1 if the glyph is U, else 0.
REQ-021 SHALL pulse msg_done for one cycle when the 16th glyph matches, and return msg_index to 0.
REQ-022 SHALL update the tracker on acceptance even when overflow drops the glyph.

Reset
REQ-023 SHALL, while rst_n=0: empty the FIFO, set last accepted pattern to blank, clear the counter and the tracker, and drive out_valid=0, out_code=0, overflow=0, msg_done=0, msg_index=0.
REQ-024 SHALL discard a partially counted hold when reset asserts mid-hold; counting restarts from the first sample after release.

Configuration
REQ-025 SHALL, with SEG7_READER_MSG_EN defined, include the message tracker (REQ-020..022).
REQ-026 SHALL, without SEG7_READER_MSG_EN, omit the tracker logic and tie msg_done and msg_index to 0; decoder and FIFO are unchanged.

Structure
REQ-027 SHALL place glyph code constants, the 7-bit pattern constants and the 16-entry expected-message table in shared package seg7_pkg.
REQ-028 SHALL implement the queue as sub-module seg7_fifo (push, pop, full, empty, parameter DEPTH).

Verification
REQ-029 SHALL cover: A held 4 cycles, out_ready=1 -> single out_code=1 with out_valid high one cycle; held 20 cycles -> still one output.
REQ-030 SHALL cover: B held 3 cycles, then C held 4 cycles -> only out_code=3; no B output.
REQ-031 SHALL cover: full message, each glyph held 6 cycles -> 16 codes in order, msg_done pulses once, msg_index returns to 0 (macro defined); macro undefined -> same codes, msg_done stays 0.
REQ-032 SHALL cover: out_ready=0, five distinct glyphs -> four queued, overflow=1, fifth lost; draining then yields the first four in order.
REQ-033 SHALL cover: 1111111 held 4 cycles after U -> out_code=15 and msg_index=0; C, blank, C -> two code-3 outputs.
REQ-034 SHALL cover: rst_n low at cycle 2 of a 4-cycle hold -> no output; all outputs 0 during reset.

Source files
------------

// File: rtl/seg7_pkg.sv
// Glyph codes, segment patterns, pattern decoder and expected-message table for seg7_reader.
// Pure definitions; no timing or flow control lives here.
package seg7_pkg;

  localparam logic [3:0] G_U     = 4'd0;
  localparam logic [3:0] G_A     = 4'd1;
  localparam logic [3:0] G_B     = 4'd2;
  localparam logic [3:0] G_C     = 4'd3;
  localparam logic [3:0] G_DASH  = 4'd4;
  localparam logic [3:0] G_E     = 4'd5;
  localparam logic [3:0] G_L     = 4'd6;
  localparam logic [3:0] G_T     = 4'd7;
  localparam logic [3:0] G_R     = 4'd8;
  localparam logic [3:0] G_O     = 4'd9;
  localparam logic [3:0] G_N     = 4'd10;
  localparam logic [3:0] G_I     = 4'd11;
  localparam logic [3:0] G_BLANK = 4'd12;
  localparam logic [3:0] G_UNK   = 4'd15;

  // Bit order: {middle, upper-left, lower-left, bottom, lower-right, upper-right, top}
  localparam logic [6:0] P_U     = 7'b0111110;
  localparam logic [6:0] P_A     = 7'b1110111;
  localparam logic [6:0] P_B     = 7'b1111100;
  localparam logic [6:0] P_C     = 7'b0111001;
  localparam logic [6:0] P_DASH  = 7'b1000000;
  localparam logic [6:0] P_E     = 7'b1111001;
  localparam logic [6:0] P_L     = 7'b0111000;
  localparam logic [6:0] P_T     = 7'b0110001;
  localparam logic [6:0] P_R     = 7'b1010000;
  localparam logic [6:0] P_O     = 7'b0111111;
  localparam logic [6:0] P_N     = 7'b1010100;
  localparam logic [6:0] P_I     = 7'b0110000;
  localparam logic [6:0] P_BLANK = 7'b0000000;

  // "UABC-ELECTRONICA"
  localparam logic [3:0] MSG_TABLE [16] = '{
    G_U, G_A, G_B, G_C, G_DASH, G_E, G_L, G_E,
    G_C, G_T, G_R, G_O, G_N, G_I, G_C, G_A
  };

  function automatic logic [3:0] decode(input logic [6:0] pat);
    logic [3:0] g;
    case (pat)
      P_U:     g = G_U;
      P_A:     g = G_A;
      P_B:     g = G_B;
      P_C:     g = G_C;
      P_DASH:  g = G_DASH;
      P_E:     g = G_E;
      P_L:     g = G_L;
      P_T:     g = G_T;
      P_R:     g = G_R;
      P_O:     g = G_O;
      P_N:     g = G_N;
      P_I:     g = G_I;
      P_BLANK: g = G_BLANK;
      default: g = G_UNK;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg7_fifo.sv
// Circular-buffer FIFO; write visible at head the cycle after push, head shown combinationally.
// Push is ignored when full unless a pop happens in the same cycle; pop on empty is ignored.
module seg7_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push_ok;
  logic          pop_ok;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign pop_ok   = pop && !empty;
  // On a full FIFO a simultaneous pop frees the slot being written.
  assign push_ok  = push && (!full || pop_ok);
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/seg7_reader.sv
// Debounces a 7-segment bus into glyph codes queued for a valid/ready consumer; out_valid rises one
// cycle after a pattern is accepted, full queue drops glyphs (sticky overflow). Tracker: SEG7_READER_MSG_EN.
import seg7_pkg::*;

module seg7_reader #(
  parameter int STABLE_CYCLES = 4,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] segments,
  output logic [3:0] out_code,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       overflow,
  output logic       msg_done,
  output logic [3:0] msg_index
);

  localparam logic [3:0] ACCEPT_AT = 4'(STABLE_CYCLES - 1);

  logic [6:0] seg_q;
  logic [6:0] last_pat;
  logic [3:0] cnt;
  logic [3:0] code;
  logic       accept;
  logic       glyph_acc;
  logic       pop;
  logic       full;
  logic       empty;

  // Acceptance happens on the edge that takes the count to STABLE_CYCLES.
  assign accept    = (cnt == ACCEPT_AT) && (segments == seg_q) && (segments != last_pat);
  assign code      = decode(segments);
  assign glyph_acc = accept && (code != G_BLANK);
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q    <= P_BLANK;
      cnt      <= 4'd0;
      last_pat <= P_BLANK;
      overflow <= 1'b0;
    end else begin
      seg_q <= segments;
      if (cnt == 4'd0 || segments != seg_q) cnt <= 4'd1;
      else if (cnt != 4'hF)                 cnt <= cnt + 4'd1;
      if (accept) last_pat <= segments;
      if (glyph_acc && full && !pop) overflow <= 1'b1;
    end
  end

  seg7_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (4)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (glyph_acc),
    .push_data (code),
    .pop       (pop),
    .pop_data  (out_code),
    .full      (full),
    .empty     (empty)
  );

`ifdef SEG7_READER_MSG_EN
  // Tracker follows every accepted glyph, including ones the full queue drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msg_index <= 4'd0;
      msg_done  <= 1'b0;
    end else begin
      msg_done <= 1'b0;
      if (glyph_acc) begin
        if (code == MSG_TABLE[msg_index]) begin
          if (msg_index == 4'd15) begin
            msg_index <= 4'd0;
            msg_done  <= 1'b1;
          end else begin
            msg_index <= msg_index + 4'd1;
          end
        end else begin
          msg_index <= (code == G_U) ? 4'd1 : 4'd0;
        end
      end
    end
  end
`else
  assign msg_done  = 1'b0;
  assign msg_index = 4'd0;
`endif

endmodule

// File: tb/tb_seg7_reader.sv
// Directed bench for seg7_reader: debounce, blank separation, queue overflow, message tracking, reset.
module tb_seg7_reader;

  localparam logic [6:0] P_U  = 7'h3E;
  localparam logic [6:0] P_A  = 7'h77;
  localparam logic [6:0] P_B  = 7'h7C;
  localparam logic [6:0] P_C  = 7'h39;
  localparam logic [6:0] P_DS = 7'h40;
  localparam logic [6:0] P_E  = 7'h79;
  localparam logic [6:0] P_L  = 7'h38;
  localparam logic [6:0] P_T  = 7'h31;
  localparam logic [6:0] P_R  = 7'h50;
  localparam logic [6:0] P_O  = 7'h3F;
  localparam logic [6:0] P_N  = 7'h54;
  localparam logic [6:0] P_I  = 7'h30;
  localparam logic [6:0] P_BL = 7'h00;
  localparam logic [6:0] P_X  = 7'h7F;

`ifdef SEG7_READER_MSG_EN
  localparam bit MSG_EN = 1'b1;
`else
  localparam bit MSG_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] segments;
  logic       out_ready;
  logic [3:0] out_code;
  logic       out_valid;
  logic       overflow;
  logic       msg_done;
  logic [3:0] msg_index;

  int tests = 0;
  int fails = 0;
  int valid_cycles = 0;
  int done_cnt = 0;
  logic [3:0] got [$];

  logic [6:0] msg_pat [16] = '{P_U, P_A, P_B, P_C, P_DS, P_E, P_L, P_E,
                               P_C, P_T, P_R, P_O, P_N, P_I, P_C, P_A};
  int msg_code [16] = '{0, 1, 2, 3, 4, 5, 6, 5, 3, 7, 8, 9, 10, 11, 3, 1};

  seg7_reader #(.STABLE_CYCLES(4), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .segments  (segments),
    .out_code  (out_code),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overflow  (overflow),
    .msg_done  (msg_done),
    .msg_index (msg_index)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Record the transfer that the coming rising edge performs, then move to the next falling edge.
  task automatic tick();
    if (out_valid === 1'b1) valid_cycles++;
    if (out_valid === 1'b1 && out_ready === 1'b1) got.push_back(out_code);
    @(negedge clk);
    if (msg_done === 1'b1) done_cnt++;
  endtask

  task automatic hold(input logic [6:0] pat, input int n);
    segments = pat;
    repeat (n) tick();
  endtask

  task automatic clear();
    got.delete();
    valid_cycles = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    segments = P_A;
    out_ready = 1'b1;
    repeat (3) tick();
    check("rst_valid", out_valid, 0);
    check("rst_code", out_code, 0);
    check("rst_overflow", overflow, 0);
    check("rst_done", msg_done, 0);
    check("rst_index", msg_index, 0);

    rst_n = 1'b1;
    clear();
    hold(P_A, 4);
    hold(P_BL, 6);
    check("a4_count", got.size(), 1);
    check("a4_code", got[0], 1);
    check("a4_valid_cycles", valid_cycles, 1);

    clear();
    hold(P_A, 20);
    hold(P_BL, 6);
    check("a20_count", got.size(), 1);
    check("a20_code", got[0], 1);
    check("a20_valid_cycles", valid_cycles, 1);

    clear();
    hold(P_B, 3);
    hold(P_C, 4);
    hold(P_BL, 6);
    check("glitch_count", got.size(), 1);
    check("glitch_code", got[0], 3);

    clear();
    hold(P_U, 6);
    check("idx_after_u", msg_index, MSG_EN ? 1 : 0);
    hold(P_X, 4);
    hold(P_BL, 6);
    check("unk_count", got.size(), 2);
    check("unk_code", got[1], 15);
    check("unk_index", msg_index, 0);

    clear();
    hold(P_C, 4);
    hold(P_BL, 4);
    hold(P_C, 4);
    hold(P_BL, 6);
    check("rep_count", got.size(), 2);
    check("rep_code0", got[0], 3);
    check("rep_code1", got[1], 3);

    check("ovf_before", overflow, 0);
    out_ready = 1'b0;
    clear();
    hold(P_E, 5);
    hold(P_L, 5);
    hold(P_T, 5);
    hold(P_R, 5);
    hold(P_O, 5);
    check("ovf_set", overflow, 1);
    check("ovf_valid", out_valid, 1);
    check("ovf_head_stable", out_code, 5);
    out_ready = 1'b1;
    hold(P_BL, 8);
    check("drain_count", got.size(), 4);
    check("drain_0", got[0], 5);
    check("drain_1", got[1], 6);
    check("drain_2", got[2], 7);
    check("drain_3", got[3], 8);

    clear();
    done_cnt = 0;
    for (int i = 0; i < 16; i++) hold(msg_pat[i], 6);
    hold(P_BL, 6);
    check("msg_count", got.size(), 16);
    for (int i = 0; i < 16; i++) check($sformatf("msg_code_%0d", i), got[i], msg_code[i]);
    check("msg_done_pulses", done_cnt, MSG_EN ? 1 : 0);
    check("msg_index_end", msg_index, 0);

    clear();
    segments = P_A;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    tick();
    check("midrst_valid", out_valid, 0);
    check("midrst_code", out_code, 0);
    check("midrst_overflow", overflow, 0);
    check("midrst_done", msg_done, 0);
    check("midrst_index", msg_index, 0);
    rst_n = 1'b1;
    repeat (3) tick();
    check("restart_3_samples", out_valid, 0);
    tick();
    check("restart_4_valid", out_valid, 1);
    check("restart_4_code", out_code, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
